// File: rtl/nf_reg_scan_if.sv
// rtl/nf_reg_scan_if.sv - word stream from the register scanner to its sink
interface nf_reg_scan_if;
  logic [31:0] tx_data;
  logic [4:0]  tx_idx;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output tx_data,
    output tx_idx,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_idx,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/nf_reg_scan.sv
// rtl/nf_reg_scan.sv - debug walker over register file read port 0, streams FIRST_REG..LAST_REG
// Optional NF_REG_SCAN_HEADER_EN prepends a "REGS" marker word to every scan.
module nf_reg_scan #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [4:0]   ra0,
  input  logic [31:0]  rd0,
  nf_reg_scan_if.master tx
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_READ = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
  localparam logic [4:0] LAST_A  = 5'(LAST_REG);

`ifdef NF_REG_SCAN_HEADER_EN
  localparam logic [31:0] HDR_WORD = 32'h5245_4753;
`endif

  generate
    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
      $error("nf_reg_scan: illegal register range FIRST_REG=%0d LAST_REG=%0d", FIRST_REG, LAST_REG);
    end
  endgenerate

  logic [2:0]  state;
  logic [4:0]  addr;
  logic [31:0] tx_data_q;
  logic [4:0]  tx_idx_q;
  logic        tx_valid_c;

  assign tx_valid_c  = (state == S_SEND) || (state == S_HDR);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign ra0         = ((state == S_READ) || (state == S_SEND)) ? addr : 5'd0;
  assign tx.tx_valid = tx_valid_c;
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_idx   = tx_idx_q;

  // Termination is checked before the increment, so addr never wraps past 31.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      addr      <= 5'd0;
      tx_data_q <= 32'd0;
      tx_idx_q  <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr <= FIRST_A;
`ifdef NF_REG_SCAN_HEADER_EN
            tx_data_q <= HDR_WORD;
            tx_idx_q  <= FIRST_A;
            state     <= S_HDR;
`else
            state     <= S_READ;
`endif
          end
        end
`ifdef NF_REG_SCAN_HEADER_EN
        S_HDR: begin
          if (tx.tx_ready) begin
            state <= S_READ;
          end
        end
`endif
        S_READ: begin
          tx_data_q <= rd0;
          tx_idx_q  <= addr;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (tx.tx_ready) begin
            if (addr == LAST_A) begin
              state <= S_DONE;
            end else begin
              addr  <= addr + 5'd1;
              state <= S_READ;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nf_reg_scan.sv
// tb/tb_nf_reg_scan.sv - scoreboard bench for nf_reg_scan (full range and 30..31 instances)
module tb_nf_reg_scan;

`ifdef NF_REG_SCAN_HEADER_EN
  localparam int HDR_EXTRA = 1;
`else
  localparam int HDR_EXTRA = 0;
`endif

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } word_t;

  typedef struct {
    int          stall_idx;
    int          stall_n;
    int          poke_idx;
    logic [31:0] poke_val;
    bit          extra_starts;
    int          exp_cycles;
  } vec_t;

  logic        clk;
  logic        resetn;
  logic        start_a, start_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [4:0]  ra0_a, ra0_b;
  logic [31:0] rd0_a, rd0_b;
  logic [31:0] regs [32];

  int tests;
  int fails;
  int done_cnt_a;

  word_t qa[$];
  word_t qb[$];

  nf_reg_scan_if ifa ();
  nf_reg_scan_if ifb ();

  nf_reg_scan #(.FIRST_REG(0), .LAST_REG(31)) dut (
    .clk(clk), .resetn(resetn), .start(start_a), .busy(busy_a), .done(done_a),
    .ra0(ra0_a), .rd0(rd0_a), .tx(ifa)
  );

  nf_reg_scan #(.FIRST_REG(30), .LAST_REG(31)) dut2 (
    .clk(clk), .resetn(resetn), .start(start_b), .busy(busy_b), .done(done_b),
    .ra0(ra0_b), .rd0(rd0_b), .tx(ifb)
  );

  assign rd0_a = (ra0_a == 5'd0) ? 32'd0 : regs[ra0_a];
  assign rd0_b = (ra0_b == 5'd0) ? 32'd0 : regs[ra0_b];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input int i);
    return (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Handshakes are sampled on the falling edge, half a cycle before the edge that completes them.
  always @(negedge clk) begin
    word_t w;
    if (resetn && ifa.tx_valid && ifa.tx_ready) begin
      if (qa.size() == 0) begin
        check("unexpected_word_a", {27'd0, ifa.tx_idx}, 32'hFFFF_FFFF);
      end else begin
        w = qa.pop_front();
        check("word_a_idx", {27'd0, ifa.tx_idx}, {27'd0, w.idx});
        check("word_a_data", ifa.tx_data, w.data);
      end
    end
    if (resetn && ifb.tx_valid && ifb.tx_ready) begin
      if (qb.size() == 0) begin
        check("unexpected_word_b", {27'd0, ifb.tx_idx}, 32'hFFFF_FFFF);
      end else begin
        w = qb.pop_front();
        check("word_b_idx", {27'd0, ifb.tx_idx}, {27'd0, w.idx});
        check("word_b_data", ifb.tx_data, w.data);
      end
    end
  end

  always @(posedge clk) begin
    if (resetn && done_a) done_cnt_a++;
  end

  task automatic push_header_a();
`ifdef NF_REG_SCAN_HEADER_EN
    qa.push_back('{idx: 5'd0, data: 32'h5245_4753});
`endif
  endtask

  task automatic run_scan(input vec_t v, input int n);
    int cycles;
    int stall_cnt;
    bit got;
    push_header_a();
    for (int i = 0; i < 32; i++) begin
      qa.push_back('{idx: 5'(i), data: (i == v.poke_idx) ? v.poke_val : model(i)});
    end
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cycles = 0;
    stall_cnt = 0;
    got = 1'b0;
    while (!got && cycles < 1000) begin
      if (ifa.tx_valid && int'(ifa.tx_idx) == v.stall_idx && busy_a && ra0_a == 5'(v.stall_idx)
          && stall_cnt < v.stall_n) begin
        ifa.tx_ready = 1'b0;
        stall_cnt++;
        check($sformatf("stall_valid_%0d", n), {31'd0, ifa.tx_valid}, 32'd1);
        check($sformatf("stall_data_%0d", n), ifa.tx_data, model(v.stall_idx));
        check($sformatf("stall_ra0_%0d", n), {27'd0, ra0_a}, 32'(v.stall_idx));
      end else begin
        ifa.tx_ready = 1'b1;
      end
      if (v.poke_idx > 0 && ifa.tx_valid && ra0_a != 5'd0 && int'(ifa.tx_idx) == v.poke_idx - 1) begin
        regs[v.poke_idx] = v.poke_val;
      end
      start_a = v.extra_starts && (cycles == 3 || cycles == 20 || cycles == 40);
      @(posedge clk); #1;
      cycles++;
      if (done_a) got = 1'b1;
    end
    start_a = 1'b0;
    ifa.tx_ready = 1'b1;
    check($sformatf("done_cycles_%0d", n), 32'(cycles), 32'(v.exp_cycles));
    check($sformatf("busy_at_done_%0d", n), {31'd0, busy_a}, 32'd1);
    @(posedge clk); #1;
    check($sformatf("busy_after_%0d", n), {31'd0, busy_a}, 32'd0);
    check($sformatf("done_pulse_%0d", n), {31'd0, done_a}, 32'd0);
    check($sformatf("queue_empty_%0d", n), 32'(qa.size()), 32'd0);
    if (v.poke_idx > 0) regs[v.poke_idx] = model(v.poke_idx);
    qa.delete();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_done"}, {31'd0, done_a}, 32'd0);
    check({tag, "_valid"}, {31'd0, ifa.tx_valid}, 32'd0);
    check({tag, "_data"}, ifa.tx_data, 32'd0);
    check({tag, "_idx"}, {27'd0, ifa.tx_idx}, 32'd0);
    check({tag, "_ra0"}, {27'd0, ra0_a}, 32'd0);
  endtask

  initial begin
    vec_t vecs [4];
    int cycles;
    int done_before;
    bit got;
    bit ra0_bad;

    vecs[0] = '{stall_idx: -1, stall_n: 0, poke_idx: -1, poke_val: 32'd0, extra_starts: 1'b1,
                exp_cycles: 64 + HDR_EXTRA};
    vecs[1] = '{stall_idx: 3, stall_n: 5, poke_idx: -1, poke_val: 32'd0, extra_starts: 1'b0,
                exp_cycles: 69 + HDR_EXTRA};
    vecs[2] = '{stall_idx: -1, stall_n: 0, poke_idx: 5, poke_val: 32'hDEAD_BEEF, extra_starts: 1'b0,
                exp_cycles: 64 + HDR_EXTRA};
    vecs[3] = '{stall_idx: 31, stall_n: 2, poke_idx: 17, poke_val: 32'h0BAD_F00D, extra_starts: 1'b1,
                exp_cycles: 66 + HDR_EXTRA};

    tests = 0;
    fails = 0;
    done_cnt_a = 0;
    for (int i = 0; i < 32; i++) regs[i] = model(i);
    resetn = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ifa.tx_ready = 1'b1;
    ifb.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    check("reset_b_valid", {31'd0, ifb.tx_valid}, 32'd0);
    check("reset_b_ra0", {27'd0, ra0_b}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 4; t++) run_scan(vecs[t], t);

    // Narrow range 30..31 on the second instance.
`ifdef NF_REG_SCAN_HEADER_EN
    qb.push_back('{idx: 5'd30, data: 32'h5245_4753});
`endif
    qb.push_back('{idx: 5'd30, data: model(30)});
    qb.push_back('{idx: 5'd31, data: model(31)});
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cycles = 0;
    got = 1'b0;
    ra0_bad = 1'b0;
    while (!got && cycles < 100) begin
      if (!(ra0_b == 5'd0 || ra0_b == 5'd30 || ra0_b == 5'd31)) ra0_bad = 1'b1;
      @(posedge clk); #1;
      cycles++;
      if (done_b) got = 1'b1;
    end
    check("narrow_cycles", 32'(cycles), 32'(4 + HDR_EXTRA));
    check("narrow_ra0_range", {31'd0, ra0_bad}, 32'd0);
    @(posedge clk); #1;
    check("narrow_busy_after", {31'd0, busy_b}, 32'd0);
    check("narrow_ra0_idle", {27'd0, ra0_b}, 32'd0);
    check("narrow_queue_empty", 32'(qb.size()), 32'd0);

    // Reset in the middle of the scan while idx 10 is being offered.
    push_header_a();
    for (int i = 0; i < 10; i++) qa.push_back('{idx: 5'(i), data: model(i)});
    done_before = done_cnt_a;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 200) begin
      if (ifa.tx_valid && ifa.tx_idx == 5'd10 && ra0_a == 5'd10) begin
        got = 1'b1;
      end else begin
        start_a = (cycles == 2 || cycles == 5);
        @(posedge clk); #1;
        cycles++;
      end
    end
    start_a = 1'b0;
    check("reach_idx10", {31'd0, got}, 32'd1);
    resetn = 1'b0;
    #1;
    check_quiet("midreset");
    @(posedge clk); #1;
    check_quiet("midreset_hold");
    resetn = 1'b1;
    @(posedge clk); #1;
    check("midreset_no_done", 32'(done_cnt_a), 32'(done_before));
    check("midreset_queue", 32'(qa.size()), 32'd0);
    qa.delete();

    run_scan(vecs[0], 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
